// File: rtl/ahb_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_pkg
// Shared AHB-Lite types and helpers for the SRAM slave:
//   htrans_t      - transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_t       - transfer size encoding (byte/half/word)
//   hburst_t      - burst type encoding (informational only in this slave)
//   HRESP_OKAY / HRESP_ERROR - response codes
//   slave_state_t - slave FSM states (IDLE, WAIT, DATA, ERR1, ERR2)
//   lane_be()     - little-endian byte-lane enable decode from size/address
// ---------------------------------------------------------------------------
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_t;

  // Byte-lane enables for a transfer. Sizes above word are treated as a word.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_mem
// DEPTH x 32 word RAM with a byte-masked write port and a registered read
// port. The read register only loads on rd_en, so it holds its word between
// reads. rd_fwd_be selects, per byte lane, the write data being committed in
// the same cycle instead of the (pre-write) array contents.
// Ports:
//   clk        in   clock (posedge)
//   srst       in   synchronous reset of the read register (array untouched)
//   wr_en      in   commit write this cycle
//   wr_be      in   [3:0] byte-write enables
//   wr_idx     in   [AW-1:0] write word index
//   wr_data    in   [31:0] write data
//   rd_en      in   load read register this cycle
//   rd_idx     in   [AW-1:0] read word index
//   rd_fwd_be  in   [3:0] lanes to take from wr_data instead of the array
//   rd_data    out  [31:0] registered read data
// ---------------------------------------------------------------------------
module ahb_sram_slave_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  input  logic [3:0]    rd_fwd_be,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) begin
        mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Next read word: array bytes merged with forwarded write lanes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int i = 0; i < 4; i++) begin
        if (rd_fwd_be[i]) begin
          rd_data_d[8*i +: 8] = wr_data[8*i +: 8];
        end else begin
          rd_data_d[8*i +: 8] = mem_q[rd_idx][8*i +: 8];
        end
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_q <= 32'h0000_0000;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite SRAM slave. Holds the transfer FSM, the address-phase latch, the
// byte-lane decode and read-after-write forwarding; storage lives in
// ahb_sram_slave_mem.
// Optional feature macro: AHB_SRAM_SLAVE_ERR_EN
//   defined   - out-of-range index, HSIZE > 2 or misaligned half/word access
//               returns a two-cycle ERROR (ERR1 then ERR2), no memory access.
//   undefined - HRESP tied OKAY, index wraps modulo MEM_DEPTH, HSIZE > 2 is a word.
// Ports:
//   HCLK       in   bus clock (posedge)
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   [ADDR_W-1:0] byte address (address phase)
//   HTRANS     in   [1:0] transfer type
//   HWRITE     in   1 = write
//   HSIZE      in   [2:0] transfer size
//   HBURST     in   [2:0] burst type (not used for addressing)
//   HWDATA     in   [DATA_W-1:0] write data (data phase)
//   HREADY     in   bus-level ready
//   HREADYOUT  out  this slave's ready
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  [DATA_W-1:0] read data
// ---------------------------------------------------------------------------
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] WAIT_RELOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  slave_state_t  state_q, state_d;
  logic          hreadyout_q, hreadyout_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          ph_write_q, ph_write_d;
  logic [3:0]    ph_be_q, ph_be_d;
  logic [AW-1:0] ph_idx_q, ph_idx_d;

  logic          accept_s;
  logic          err_s;
  logic          wr_commit_s;
  logic          rd_start_s;
  logic [31:0]   idx_ext_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic [3:0]    fwd_be_s;
  slave_state_t  launch_state_s;
  logic          unused_s;

  // HBURST is informational; addresses always come from HADDR.
  assign unused_s = ^HBURST;

  // Address-phase decode: accept, word index, lanes and error classification.
  always_comb begin
    // hreadyout_q guards against accepting while our own data phase is stalled.
    accept_s  = HSEL & HREADY & hreadyout_q &
                ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    idx_ext_s = 32'(HADDR[ADDR_W-1:2]);
    idx_s     = AW'(idx_ext_s % 32'(MEM_DEPTH));
    be_s      = lane_be(HSIZE, HADDR[1:0]);
`ifdef AHB_SRAM_SLAVE_ERR_EN
    err_s     = (idx_ext_s >= 32'(MEM_DEPTH)) ||
                (HSIZE > 3'd2) ||
                ((HSIZE == 3'd1) && HADDR[0]) ||
                ((HSIZE == 3'd2) && (HADDR[1:0] != 2'd0));
`else
    err_s     = 1'b0;
`endif
  end

  // Memory control: commit on the ready data cycle, read on a clean read accept.
  always_comb begin
    wr_commit_s = (state_q == ST_DATA) & ph_write_q & ~HRESET;
    rd_start_s  = accept_s & ~HWRITE & ~err_s & ~HRESET;
    // A read accepted on the same edge a write to its word commits sees the new bytes.
    if (wr_commit_s && (ph_idx_q == idx_s)) begin
      fwd_be_s = ph_be_q;
    end else begin
      fwd_be_s = 4'b0000;
    end
  end

  // FSM next state, wait counter and address-phase latch.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = WAIT_RELOAD;
    ph_write_d = ph_write_q;
    ph_be_d    = ph_be_q;
    ph_idx_d   = ph_idx_q;

    if (accept_s) begin
      ph_write_d = HWRITE;
      ph_be_d    = be_s;
      ph_idx_d   = idx_s;
    end else begin
      ph_write_d = ph_write_q;
    end

    // Where a ready cycle leads: a new access phase or back to idle.
    if (!accept_s) begin
      launch_state_s = ST_IDLE;
    end else if (err_s) begin
      launch_state_s = ST_ERR1;
    end else if (WAIT_STATES > 0) begin
      launch_state_s = ST_WAIT;
    end else begin
      launch_state_s = ST_DATA;
    end

    case (state_q)
      ST_IDLE, ST_DATA: state_d = launch_state_s;
      ST_WAIT: begin
        if (wcnt_q == 3'd0) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
          wcnt_d  = wcnt_q - 3'd1;
        end
      end
`ifdef AHB_SRAM_SLAVE_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = launch_state_s;
`endif
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
  end

  // FSM and phase-latch registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      wcnt_q      <= 3'd0;
      ph_write_q  <= 1'b0;
      ph_be_q     <= 4'b0000;
      ph_idx_q    <= {AW{1'b0}};
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      wcnt_q      <= wcnt_d;
      ph_write_q  <= ph_write_d;
      ph_be_q     <= ph_be_d;
      ph_idx_q    <= ph_idx_d;
    end
  end

  assign HREADYOUT = hreadyout_q;

`ifdef AHB_SRAM_SLAVE_ERR_EN
  logic hresp_q, hresp_d;

  // ERROR response is asserted for both ERR1 and ERR2.
  always_comb begin
    if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
      hresp_d = HRESP_ERROR;
    end else begin
      hresp_d = HRESP_OKAY;
    end
  end

  // Response register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hresp_q <= HRESP_OKAY;
    end else begin
      hresp_q <= hresp_d;
    end
  end

  assign HRESP = hresp_q;
`else
  assign HRESP = HRESP_OKAY;
`endif

  ahb_sram_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (HCLK),
    .srst      (HRESET),
    .wr_en     (wr_commit_s),
    .wr_be     (ph_be_q),
    .wr_idx    (ph_idx_q),
    .wr_data   (HWDATA[31:0]),
    .rd_en     (rd_start_s),
    .rd_idx    (idx_s),
    .rd_fwd_be (fwd_be_s),
    .rd_data   (HRDATA[31:0])
  );

endmodule
